// File: rtl/adc_pong_scheduler.sv
// LTC2308 sweep sequencer: one CONVST + 12-bit SPI exchange per channel each frame,
// results published as a tagged stream and as two registered paddle positions.
module adc_pong_scheduler #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int ACQ_CYCLES  = 20,
    parameter int NUM_CH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic        result_valid,
    output logic [2:0]  result_ch,
    output logic [11:0] result_data,
    output logic [15:0] pongbar1_y,
    output logic [15:0] pongbar2_y,
    output logic        busy,
    output logic        sweep_done,
    output logic        overrun
);

    localparam int PER     = 2 * CLK_DIV;
    localparam int MAX_A   = (CONV_CYCLES > ACQ_CYCLES) ? CONV_CYCLES : ACQ_CYCLES;
    localparam int CNT_MAX = (MAX_A > PER) ? MAX_A : PER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        SHIFT = 3'd2,
        ACQ   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Config bit for bit period bidx of transaction txn; the extra final txn re-selects ch0.
    function automatic logic cfg_bit(input logic [3:0] txn, input logic [3:0] bidx);
        logic [2:0] ch;
        logic [5:0] word;
        ch   = (txn < 4'(NUM_CH)) ? txn[2:0] : 3'd0;
        word = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
        return (bidx < 4'd6) ? word[3'(4'd5 - bidx)] : 1'b0;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [3:0]       t_q, t_d;
    logic [11:0]      shift_q, shift_d;
    logic             pend_q, pend_d;
    logic             convst_q, convst_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;
    logic             valid_q, valid_d;
    logic [2:0]       rch_q, rch_d;
    logic [11:0]      rdata_q, rdata_d;
    logic [15:0]      pb1_q, pb1_d;
    logic [15:0]      pb2_q, pb2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    // Next-state sequencing and output decode; outputs are derived from next-state values
    // so the registered pins line up with the state they belong to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        t_d       = t_q;
        shift_d   = shift_q;
        overrun_d = overrun_q | (frame_start & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    t_d     = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                // SDO is captured on the first clk of each SCK high phase.
                if (cnt_q == CNT_W'(CLK_DIV)) begin
                    shift_d = {shift_q[10:0], adc_sdo};
                end else begin
                    shift_d = shift_q;
                end
                if (cnt_q == CNT_W'(PER - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 4'd11) begin
                        state_d = ACQ;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACQ: begin
                if (cnt_q == CNT_W'(ACQ_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (t_q < 4'(NUM_CH)) begin
                        state_d = CONV;
                        t_d     = t_q + 4'd1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = 4'd0;
                t_d     = 4'd0;
            end
        endcase

        convst_d = (state_d == CONV) && (cnt_d < CNT_W'(2));
        sck_d    = (state_d == SHIFT) && (cnt_d >= CNT_W'(CLK_DIV));
        sdi_d    = (state_d == SHIFT) ? cfg_bit(t_d, bit_d) : 1'b0;
        busy_d   = (state_d == CONV) || (state_d == SHIFT) || (state_d == ACQ);
        done_d   = (state_d == DONE);

        // Transaction 0 returns the previous sweep's dummy conversion, so it is never issued.
        pend_d  = (state_q == SHIFT) && (state_d == ACQ) && (t_q != 4'd0);
        valid_d = pend_q;
        rch_d   = pend_q ? 3'(t_q - 4'd1) : rch_q;
        rdata_d = pend_q ? shift_q : rdata_q;
        pb1_d   = (pend_q && (t_q == 4'd1)) ? {4'd0, shift_q} : pb1_q;
        pb2_d   = (pend_q && (t_q == 4'd2)) ? {4'd0, shift_q} : pb2_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            t_q       <= 4'd0;
            shift_q   <= 12'd0;
            pend_q    <= 1'b0;
            convst_q  <= 1'b0;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
            valid_q   <= 1'b0;
            rch_q     <= 3'd0;
            rdata_q   <= 12'd0;
            pb1_q     <= 16'd0;
            pb2_q     <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            t_q       <= t_d;
            shift_q   <= shift_d;
            pend_q    <= pend_d;
            convst_q  <= convst_d;
            sck_q     <= sck_d;
            sdi_q     <= sdi_d;
            valid_q   <= valid_d;
            rch_q     <= rch_d;
            rdata_q   <= rdata_d;
            pb1_q     <= pb1_d;
            pb2_q     <= pb2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign adc_convst   = convst_q;
    assign adc_sck      = sck_q;
    assign adc_sdi      = sdi_q;
    assign result_valid = valid_q;
    assign result_ch    = rch_q;
    assign result_data  = rdata_q;
    assign pongbar1_y   = pb1_q;
    assign pongbar2_y   = pb2_q;
    assign busy         = busy_q;
    assign sweep_done   = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_pong_scheduler.sv
// Bench for adc_pong_scheduler: LTC2308 behavioural model, result scoreboard,
// table of sweeps plus hand-written overrun and mid-shift reset sequences.
module tb_adc_pong_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo;
    logic        result_valid;
    logic [2:0]  result_ch;
    logic [11:0] result_data;
    logic [15:0] pongbar1_y;
    logic [15:0] pongbar2_y;
    logic        busy;
    logic        sweep_done;
    logic        overrun;

    adc_pong_scheduler #(
        .CLK_DIV(2), .CONV_CYCLES(80), .ACQ_CYCLES(20), .NUM_CH(2)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
        .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
        .pongbar1_y(pongbar1_y), .pongbar2_y(pongbar2_y),
        .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] v0;
        logic [11:0] v1;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t        vecs[4];
    logic [14:0] exp_q[$];
    logic [11:0] adc_val[8];

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          txn_idx = 0;
    int          sck_cnt = 0;
    int          convst_start = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          sweeps_expected = 0;
    bit          done_seen = 1'b0;
    logic        convst_p = 1'b0;
    logic        sck_p = 1'b0;
    logic [15:0] pb1_p = 16'd0;
    logic [15:0] pb2_p = 16'd0;
    logic [11:0] sdo_sh = 12'd0;
    logic [5:0]  cfg_bits = 6'd0;
    logic [2:0]  pend_ch = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One negedge: advance the ADC model and check protocol and scoreboard events.
    task automatic step();
        logic [14:0] e;
        @(negedge clk);
        cyc++;
        if (adc_convst && !convst_p) begin
            if (txn_idx >= 1) begin
                chk("txn_period", cyc - convst_start, 148);
                chk("sck_per_txn", sck_cnt, 12);
            end
            txn_idx++;
            convst_start = cyc;
            sdo_sh   = adc_val[pend_ch];
            adc_sdo  = sdo_sh[11];
            sck_cnt  = 0;
            cfg_bits = 6'd0;
        end
        if (!adc_convst && convst_p) chk("convst_width", cyc - convst_start, 2);
        if (adc_sck && !sck_p) begin
            sck_cnt++;
            if (sck_cnt == 1) chk("convst_to_sck", cyc - convst_start, 82);
            if (sck_cnt <= 6) cfg_bits = {cfg_bits[4:0], adc_sdi};
            else chk("sdi_pad_zero", adc_sdi, 0);
            if (sck_cnt == 6) begin
                chk("sdi_cfg", cfg_bits, (txn_idx == 2) ? 6'b110010 : 6'b100010);
                pend_ch = {cfg_bits[3], cfg_bits[2], cfg_bits[4]};
            end
        end
        if (!adc_sck && sck_p) begin
            sdo_sh  = {sdo_sh[10:0], 1'b0};
            adc_sdo = sdo_sh[11];
        end
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", result_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result_ch", result_ch, e[14:12]);
                chk("result_data", result_data, e[11:0]);
                if (e[14:12] == 3'd0) chk("pongbar1_y", pongbar1_y, {4'h0, e[11:0]});
                else chk("pongbar2_y", pongbar2_y, {4'h0, e[11:0]});
            end
        end else if (!reset) begin
            chk("pb1_hold", pongbar1_y, pb1_p);
            chk("pb2_hold", pongbar2_y, pb2_p);
        end
        if (sweep_done) begin
            done_cnt++;
            done_seen = 1'b1;
            done_cyc  = cyc;
            chk("txns_per_sweep", txn_idx, 3);
            chk("sck_last_txn", sck_cnt, 12);
        end
        convst_p = adc_convst;
        sck_p    = adc_sck;
        pb1_p    = pongbar1_y;
        pb2_p    = pongbar2_y;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_convst"}, adc_convst, 0);
        chk({tag, "_sck"}, adc_sck, 0);
        chk({tag, "_sdi"}, adc_sdi, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_ch"}, result_ch, 0);
        chk({tag, "_data"}, result_data, 0);
        chk({tag, "_pb1"}, pongbar1_y, 0);
        chk({tag, "_pb2"}, pongbar2_y, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, sweep_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic start_sweep(input vec_t v, input bit push, output int start);
        adc_val[0] = v.v0;
        adc_val[1] = v.v1;
        txn_idx    = 0;
        done_seen  = 1'b0;
        start      = cyc;
        frame_start = 1'b1;
        if (push) begin
            exp_q.push_back({3'd0, v.v0});
            exp_q.push_back({3'd1, v.v1});
            sweeps_expected++;
        end
        step();
        frame_start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_sweep(input vec_t v, input int start);
        for (int i = 0; i < 1200 && !done_seen; i++) step();
        chk("sweep_done_seen", done_seen, 1);
        chk("sweep_latency", done_cyc - start, 445);
        chk("busy_at_done", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("pb1_final", pongbar1_y, v.e1);
        chk("pb2_final", pongbar2_y, v.e2);
        repeat (3) step();
        chk("sweep_done_count", done_cnt, sweeps_expected);
        chk("busy_idle", busy, 0);
    endtask

    task automatic run_sweep(input vec_t v);
        int start;
        start_sweep(v, 1'b1, start);
        finish_sweep(v, start);
    endtask

    initial begin
        int          start;
        int          d0;
        logic [15:0] hold1;
        logic [15:0] hold2;

        vecs[0] = '{12'hA5C, 12'h3F1, 16'h0A5C, 16'h03F1};
        vecs[1] = '{12'hFFF, 12'hFFF, 16'h0FFF, 16'h0FFF};
        vecs[2] = '{12'h000, 12'h000, 16'h0000, 16'h0000};
        vecs[3] = '{12'h801, 12'h7FE, 16'h0801, 16'h07FE};
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;

        reset = 1'b1;
        frame_start = 1'b0;
        adc_sdo = 1'b0;
        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        step();
        check_zero("post_reset");

        for (int i = 0; i < 4; i++) run_sweep(vecs[i]);

        // Paddles must hold between sweeps.
        run_sweep(vecs[0]);
        hold1 = pongbar1_y;
        hold2 = pongbar2_y;
        repeat (100) step();
        chk("pb1_stable", pongbar1_y, 16'h0A5C);
        chk("pb2_stable", pongbar2_y, 16'h03F1);
        chk("pb1_stable_hold", pongbar1_y, hold1);
        chk("pb2_stable_hold", pongbar2_y, hold2);

        // frame_start while busy sets overrun and does not start another sweep.
        chk("overrun_clear", overrun, 0);
        start_sweep(vecs[3], 1'b1, start);
        repeat (300) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("overrun_set", overrun, 1);
        finish_sweep(vecs[3], start);
        d0 = done_cnt;
        repeat (600) step();
        chk("no_second_sweep", done_cnt, d0);
        chk("no_second_busy", busy, 0);
        run_sweep(vecs[0]);
        chk("overrun_sticky", overrun, 1);

        // Reset during SHIFT bit 5 of the ch1-configuring transaction, with frame_start coincident.
        start_sweep(vecs[1], 1'b0, start);
        for (int i = 0; i < 600 && !(txn_idx == 2 && sck_cnt == 6); i++) step();
        chk("reached_bit5", (txn_idx == 2 && sck_cnt == 6), 1);
        reset = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check_zero("mid_reset");
        reset = 1'b0;
        exp_q.delete();
        repeat (300) step();
        chk("idle_after_reset", busy, 0);
        chk("no_result_after_reset", pongbar1_y, 0);
        run_sweep(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_pong_scheduler.md
Name: adc_pong_scheduler

Overview:
- Sequences the on-board LTC2308 ADC so that each video frame delivers fresh paddle positions to the pattern generator.
- On each frame_start pulse it runs one sweep of NUM_CH single-ended conversions: CONVST pulse, conversion wait, then a 12-bit SPI exchange.
- Results are published as a tagged stream. Channels 0 and 1 are also held in registered 16-bit paddle outputs that feed pongbar1_y_input and pongbar2_y_input.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period (minimum 1; 50 MHz / (2*2) = 12.5 MHz SCK)
CONV_CYCLES, 80, clk cycles from CONVST rise to start of shift (tCONV 1.6 us at 50 MHz)
ACQ_CYCLES, 20, idle clk cycles between transactions (tACQ)
NUM_CH, 2, channels swept per frame, 1..8, channel numbers 0..NUM_CH-1

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse (vsync edge) requesting a sweep
adc_convst  out  1  to ADC_CONVST
adc_sck  out  1  to ADC_SCK, idles low
adc_sdi  out  1  to ADC_SDI, config word MSB first
adc_sdo  in  1  from ADC_SDO
result_valid  out  1  one-cycle strobe, result_ch/result_data valid
result_ch  out  3  channel of result_data
result_data  out  12  conversion result
pongbar1_y  out  16  {4'b0, latest ch0 result}
pongbar2_y  out  16  {4'b0, latest ch1 result} (held 0 if NUM_CH=1)
busy  out  1  high from accepted frame_start until sweep_done
sweep_done  out  1  one-cycle strobe after the last result of a sweep
overrun  out  1  sticky; frame_start arrived while busy

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-transaction aborts immediately: CONVST/SCK/SDI go low on the next edge and no result is emitted.
- FSM states: IDLE, CONV, SHIFT, ACQ, DONE.
- IDLE: on frame_start, set busy=1, clear txn index t=0, go to CONV on the next cycle.
- CONV:
  - adc_convst=1 for the first 2 cycles, then 0.
  - Stay CONV_CYCLES cycles total, then go to SHIFT.
- SHIFT:
  - 12 bit periods, each 2*CLK_DIV cycles; SCK low for the first half, high for the second.
  - adc_sdi is updated at the start of each bit period.
  - Bits 0..5 carry the config word {1 (S/D), ch[0] (O/S), ch[2] (S1), ch[1] (S0), 1 (UNI), 0 (SLP)}; bits 6..11 drive 0.
  - adc_sdo is sampled on the clk cycle SCK rises and shifted MSB first into a 12-bit register.
  - After the 12th high phase, SCK returns low, then go to ACQ.
- Pipelining: the config sent in transaction t selects the channel of conversion t+1.
  - A sweep is NUM_CH+1 transactions.
  - Transaction t (0..NUM_CH-1) configures channel t; the final transaction re-configures channel 0 as a dummy.
  - Data from transaction 0 is discarded (it is the previous sweep's dummy conversion).
  - Data from transaction t>=1 is channel t-1.
- Result issue:
  - One cycle after the SHIFT→ACQ transition, for t>=1: result_valid=1, result_ch=t-1, result_data=shift reg.
  - Same cycle: pongbar1_y/pongbar2_y update if the channel is 0/1.
- ACQ: wait ACQ_CYCLES. If t < NUM_CH, increment t and go to CONV; else go to DONE.
- DONE: sweep_done=1 for one cycle, busy=0, return to IDLE. Total sweep latency = (NUM_CH+1)*(CONV_CYCLES+24*CLK_DIV+ACQ_CYCLES) + ~3 cycles.
- frame_start while busy (including the DONE cycle): ignored, overrun set to 1 until reset. frame_start coincident with reset: reset wins.
- Paddle outputs hold their last value between sweeps and never glitch mid-shift. A value changes only on its result_valid cycle.
- Bit counters wrap exactly at 12 bits and at 2*CLK_DIV cycles. The SCK count per transaction is always exactly 12.

Test Plan:
- ADC model returns 12'hA5C for ch0 and 12'h3F1 for ch1; one frame_start → results (ch0,A5C) then (ch1,3F1), pongbar1_y=16'h0A5C, pongbar2_y=16'h03F1, sweep_done once, busy low afterwards.
- Check the SDI shift of the transaction configuring ch1 → bits 110010; ch0 → 100010. Exactly 12 SCK pulses per transaction; CONVST high exactly 2 cycles.
- Timing with defaults: CONVST rise to first SCK rise = 80+2 cycles; transaction period 80+48+20 = 148 cycles; sweep length 3 transactions.
- frame_start pulsed mid-sweep → overrun=1, only one sweep executed, results unaffected; overrun stays 1 after a later idle frame_start.
- Assert reset during SHIFT bit 5 → next cycle CONVST/SCK/SDI=0 and outputs 0, no result_valid; a new frame_start gives a complete correct sweep.
- SDO all-ones then all-zeros across two frames → pongbar outputs 16'h0FFF then 16'h0000. Values stay stable between sweeps.
